// File: rtl/decode_pkg.sv
// Shared constants and types for the instruction decode stage:
// opcode encoding, instruction field layout and data widths.
package decode_pkg;
    localparam int XLEN = 8;
    localparam int ILEN = 24;
    localparam int NREG = 16;
    localparam int RIDX = 4;

    // Field bit positions within the 24-bit instruction word
    localparam int OP_HI  = 23, OP_LO  = 20;
    localparam int RD_HI  = 19, RD_LO  = 16;
    localparam int RS1_HI = 15, RS1_LO = 12;
    localparam int RS2_HI = 11, RS2_LO = 8;
    localparam int IMM_HI = 7,  IMM_LO = 0;

    // Defined opcodes; encodings 8..15 are illegal and behave as NOP
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_ADDI = 4'd3,
        OP_LI   = 4'd4,
        OP_BEQ  = 4'd5,
        OP_BNE  = 4'd6,
        OP_JMP  = 4'd7
    } opcode_e;

    // Packed view of the instruction word, matching the field positions above
    typedef struct packed {
        logic [3:0]      op;
        logic [RIDX-1:0] rd;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic [XLEN-1:0] imm;
    } instr_t;
endpackage

// File: rtl/decode_regfile.sv
// 16x8 register file: two combinational read ports with same-cycle
// writeback bypass, one write port, r0 hard-wired to zero.
module decode_regfile
    import decode_pkg::*;
(
    input  logic            CLK,
    input  logic            reset,
    input  logic [RIDX-1:0] rs1_i,
    input  logic [RIDX-1:0] rs2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [RIDX-1:0] wa_i,
    input  logic [XLEN-1:0] wd_i
);
    logic [XLEN-1:0] regs_q [NREG];

    // Read with r0 forced to zero and writeback data forwarded in-cycle
    function automatic logic [XLEN-1:0] rd_port(input logic [RIDX-1:0] idx);
        if (idx == '0)
            return '0;
        else if (we_i && wa_i == idx)
            return wd_i;
        else
            return regs_q[idx];
    endfunction

    // Storage update; reset takes priority over any writeback in that cycle
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && wa_i != '0) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Two independent read ports
    always_comb begin
        rd1_o = rd_port(rs1_i);
        rd2_o = rd_port(rs2_i);
    end
endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: IF/ID register, register file read, branch resolution
// back to fetch, and ID/EX register for the execute stage.
// Optional DECODE_PERF_EN adds saturating retired/flushed counters.
module instr_decode_stage
    import decode_pkg::*;
(
    input  logic            CLK,
    input  logic            reset,
    input  logic [ILEN-1:0] Instr,
    output logic            PCSrc,
    output logic [XLEN-1:0] immediate,
    input  logic            wb_en,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic            ex_sub,
    output logic [RIDX-1:0] ex_rd,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic            illegal
`ifdef DECODE_PERF_EN
    ,
    output logic [15:0]     perf_retired,
    output logic [15:0]     perf_flushed
`endif
);
    instr_t          ir_q;
    logic            ir_valid_q, ir_valid_d;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            take;

    logic            ex_valid_q, ex_valid_d;
    logic            ex_sub_q,   ex_sub_d;
    logic [RIDX-1:0] ex_rd_q,    ex_rd_d;
    logic [XLEN-1:0] ex_a_q,     ex_a_d;
    logic [XLEN-1:0] ex_b_q,     ex_b_d;
    logic            illegal_q,  illegal_d;

    decode_regfile u_rf (
        .CLK   (CLK),
        .reset (reset),
        .rs1_i (ir_q.rs1),
        .rs2_i (ir_q.rs2),
        .rd1_o (rs1_val),
        .rd2_o (rs2_val),
        .we_i  (wb_en),
        .wa_i  (wb_rd),
        .wd_i  (wb_data)
    );

    // Branch unit: redirect fetch on JMP or a taken conditional branch
    always_comb begin
        take = 1'b0;
        case (ir_q.op)
            OP_JMP:  take = 1'b1;
            OP_BEQ:  take = (rs1_val == rs2_val);
            OP_BNE:  take = (rs1_val != rs2_val);
            default: take = 1'b0;
        endcase
    end

    assign PCSrc     = ir_valid_q & take;
    assign immediate = ir_q.imm;

    // The slot fetched while redirecting is the single wrong-path instruction
    assign ir_valid_d = ~reset & ~PCSrc;

    // IF/ID register: instruction always captured, validity gated
    always_ff @(posedge CLK) begin
        ir_q       <= instr_t'(Instr);
        ir_valid_q <= ir_valid_d;
    end

    // ID/EX next state: operand selection per opcode
    always_comb begin
        ex_valid_d = 1'b0;
        ex_sub_d   = (ir_q.op == OP_SUB);
        ex_rd_d    = ir_q.rd;
        ex_a_d     = rs1_val;
        ex_b_d     = rs2_val;
        illegal_d  = ir_valid_q & ir_q.op[3];
        case (ir_q.op)
            OP_ADD, OP_SUB: ex_valid_d = ir_valid_q;
            OP_ADDI: begin
                ex_valid_d = ir_valid_q;
                ex_b_d     = ir_q.imm;
            end
            OP_LI: begin
                ex_valid_d = ir_valid_q;
                ex_a_d     = '0;
                ex_b_d     = ir_q.imm;
            end
            default: ex_valid_d = 1'b0;
        endcase
    end

    // ID/EX register and illegal-opcode pulse
    always_ff @(posedge CLK) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_sub_q   <= 1'b0;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_sub_q   <= ex_sub_d;
            ex_rd_q    <= ex_rd_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_sub   = ex_sub_q;
    assign ex_rd    = ex_rd_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign illegal  = illegal_q;

`ifdef DECODE_PERF_EN
    logic [15:0] perf_ret_q, perf_ret_d;
    logic [15:0] perf_flush_q, perf_flush_d;
    logic        flush_q;

    // Saturating increments; a flush cycle is an invalid IR caused by redirect
    always_comb begin
        perf_ret_d   = perf_ret_q;
        perf_flush_d = perf_flush_q;
        if (ir_valid_q && perf_ret_q != '1)
            perf_ret_d = perf_ret_q + 16'd1;
        if (!ir_valid_q && flush_q && perf_flush_q != '1)
            perf_flush_d = perf_flush_q + 16'd1;
    end

    // Counter state; flush_q remembers that the last edge was a redirect
    always_ff @(posedge CLK) begin
        if (reset) begin
            perf_ret_q   <= '0;
            perf_flush_q <= '0;
            flush_q      <= 1'b0;
        end else begin
            perf_ret_q   <= perf_ret_d;
            perf_flush_q <= perf_flush_d;
            flush_q      <= PCSrc;
        end
    end

    assign perf_retired = perf_ret_q;
    assign perf_flushed = perf_flush_q;
`endif
endmodule
